// File: rtl/iter_udiv_if.sv
// Divide request channel between the EXE stage and the iterative divider:
// dividend/divisor valid-ready channels, one result pulse, and a flush input.
interface iter_udiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0]   s_axis_dividend_tdata;
   logic               s_axis_dividend_tvalid;
   logic               s_axis_dividend_tready;
   logic [WIDTH-1:0]   s_axis_divisor_tdata;
   logic               s_axis_divisor_tvalid;
   logic               s_axis_divisor_tready;
   logic [2*WIDTH-1:0] m_axis_dout_tdata;
   logic               m_axis_dout_tvalid;
   logic               div_cancel;

   modport slave (
      input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
      input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
      input  div_cancel,
      output s_axis_dividend_tready, s_axis_divisor_tready,
      output m_axis_dout_tdata, m_axis_dout_tvalid
   );

   modport master (
      output s_axis_dividend_tdata, s_axis_dividend_tvalid,
      output s_axis_divisor_tdata, s_axis_divisor_tvalid,
      output div_cancel,
      input  s_axis_dividend_tready, s_axis_divisor_tready,
      input  m_axis_dout_tdata, m_axis_dout_tvalid
   );
endinterface

// File: rtl/iter_udiv.sv
// Radix-2 restoring unsigned divider: fixed WIDTH-iteration latency,
// result {quotient, remainder} pulsed for one cycle, cancellable at any time.
module iter_udiv #(
   parameter int unsigned WIDTH = 32
) (
   input logic        clk,
   input logic        reset,
   iter_udiv_if.slave dif
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_dvd;
   logic [WIDTH-1:0]   r_dvs;
   logic               r_dvd_held;
   logic               r_dvs_held;
   logic [WIDTH-1:0]   r_rem;
   logic [WIDTH-1:0]   r_quo;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_dout;

   logic               w_dvd_hs;
   logic               w_dvs_hs;
   logic               w_start;
   logic [WIDTH-1:0]   w_dvd_val;
   logic [WIDTH:0]     w_rsh;
   logic [WIDTH:0]     w_diff;
   logic               w_ge;
   logic [WIDTH-1:0]   w_rnext;
   logic [WIDTH-1:0]   w_qnext;

   assign dif.s_axis_dividend_tready = (r_state == IDLE) & ~r_dvd_held;
   assign dif.s_axis_divisor_tready  = (r_state == IDLE) & ~r_dvs_held;
   assign dif.m_axis_dout_tdata      = r_dout;
   assign dif.m_axis_dout_tvalid     = (r_state == DONE) & ~dif.div_cancel;

   assign w_dvd_hs  = dif.s_axis_dividend_tvalid & dif.s_axis_dividend_tready;
   assign w_dvs_hs  = dif.s_axis_divisor_tvalid & dif.s_axis_divisor_tready;
   assign w_start   = (r_dvd_held | w_dvd_hs) & (r_dvs_held | w_dvs_hs);
   assign w_dvd_val = r_dvd_held ? r_dvd : dif.s_axis_dividend_tdata;

   // The remainder stays below the divisor (or is a dividend prefix when the
   // divisor is 0), so its top bit is always 0 and the borrow decides r' >= d.
   assign w_rsh   = {r_rem, r_quo[WIDTH-1]};
   assign w_diff  = w_rsh - {1'b0, r_dvs};
   assign w_ge    = ~w_diff[WIDTH];
   assign w_rnext = w_ge ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0];
   assign w_qnext = {r_quo[WIDTH-2:0], w_ge};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_dvd_held <= 1'b0;
         r_dvs_held <= 1'b0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_cnt      <= '0;
         r_dout     <= '0;
      end else if (dif.div_cancel) begin
         r_state    <= IDLE;
         r_dvd_held <= 1'b0;
         r_dvs_held <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_dvd_hs) begin
                  r_dvd      <= dif.s_axis_dividend_tdata;
                  r_dvd_held <= 1'b1;
               end
               if (w_dvs_hs) begin
                  r_dvs      <= dif.s_axis_divisor_tdata;
                  r_dvs_held <= 1'b1;
               end
               if (w_start) begin
                  r_state <= BUSY;
                  r_rem   <= '0;
                  r_quo   <= w_dvd_val;
                  r_cnt   <= '0;
               end
            end
            BUSY: begin
               r_rem <= w_rnext;
               r_quo <= w_qnext;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(WIDTH - 1)) begin
                  r_state <= DONE;
                  r_dout  <= {w_qnext, w_rnext};
               end
            end
            DONE: begin
               r_state    <= IDLE;
               r_dvd_held <= 1'b0;
               r_dvs_held <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iter_udiv.sv
// Bench for iter_udiv: vector table plus corner sequences; results are
// checked by a negedge monitor against a queue of {value, expected cycle}.
module tb_iter_udiv;
   typedef struct {
      logic [31:0] dvd;
      logic [31:0] dvs;
      logic [31:0] quo;
      logic [31:0] rem;
   } vec_t;

   typedef struct {
      logic [63:0] dout;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int unsigned cyc = 0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   exp_t        sb[$];
   vec_t        vecs[12];

   iter_udiv_if #(.WIDTH(32)) dif ();

   iter_udiv #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .dif   (dif.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      exp_t e;
      if (dif.m_axis_dout_tvalid === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_tvalid: got tvalid=1 at cycle %0d, required no result", cyc);
         end else begin
            e = sb.pop_front();
            chk("dout", dif.m_axis_dout_tdata, e.dout);
            chk("latency_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   // Called and returns at posedge+#1; drives both operands in one cycle.
   task automatic send_both(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] q, input logic [31:0] r,
                            input bit exp_res, output int unsigned hs_cyc);
      int unsigned k = 0;
      while (!(dif.s_axis_dividend_tready && dif.s_axis_divisor_tready) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 200) begin
         n_vec++;
         n_err++;
         $display("FAIL tready_timeout: got tready low for %0d cycles, required high", k);
      end
      dif.s_axis_dividend_tdata  = a;
      dif.s_axis_dividend_tvalid = 1'b1;
      dif.s_axis_divisor_tdata   = b;
      dif.s_axis_divisor_tvalid  = 1'b1;
      hs_cyc = cyc;
      if (exp_res) sb.push_back('{dout: {q, r}, cyc: cyc + 33});
      @(posedge clk); #1;
      dif.s_axis_dividend_tvalid = 1'b0;
      dif.s_axis_divisor_tvalid  = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("drain_pending", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      int unsigned hc;
      int unsigned h2;
      int unsigned lows;
      int unsigned c0;
      logic [31:0] a;
      logic [31:0] b;

      vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1]  = '{32'd5,          32'd0,          32'hFFFFFFFF,   32'd5};
      vecs[2]  = '{32'd0,          32'd9,          32'd0,          32'd0};
      vecs[3]  = '{32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
      vecs[4]  = '{32'h80000000,   32'h10,         32'h08000000,   32'd0};
      vecs[5]  = '{32'h12345678,   32'h100,        32'h00123456,   32'h78};
      vecs[6]  = '{32'd7,          32'd7,          32'd1,          32'd0};
      vecs[7]  = '{32'd1000,       32'd3,          32'd333,        32'd1};
      vecs[8]  = '{32'd50,         32'd8,          32'd6,          32'd2};
      vecs[9]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0};
      vecs[10] = '{32'd7,          32'hFFFFFFFF,   32'd0,          32'd7};
      vecs[11] = '{32'd0,          32'd0,          32'hFFFFFFFF,   32'd0};

      dif.s_axis_dividend_tdata  = '0;
      dif.s_axis_dividend_tvalid = 1'b0;
      dif.s_axis_divisor_tdata   = '0;
      dif.s_axis_divisor_tvalid  = 1'b0;
      dif.div_cancel             = 1'b0;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_treadys", 64'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 64'b11);
      chk("reset_tvalid", 64'(dif.m_axis_dout_tvalid), 64'd0);

      // 100/7 with tready profile across the operation
      send_both(32'd100, 32'd7, 32'd14, 32'd2, 1'b1, hc);
      lows = 0;
      for (int i = 1; i <= 33; i++) begin
         if (!dif.s_axis_dividend_tready && !dif.s_axis_divisor_tready) lows++;
         @(posedge clk); #1;
      end
      chk("tready_low_cycles", 64'(lows), 64'd33);
      chk("tready_after_done", 64'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 64'b11);
      wait_drain();

      // Staggered operands; dividend channel ignores traffic while held
      c0 = cyc;
      dif.s_axis_dividend_tdata  = 32'hFFFFFFFF;
      dif.s_axis_dividend_tvalid = 1'b1;
      @(posedge clk); #1;
      dif.s_axis_dividend_tdata = 32'h00001234;
      chk("held_dvd_tready", 64'(dif.s_axis_dividend_tready), 64'd0);
      chk("free_dvs_tready", 64'(dif.s_axis_divisor_tready), 64'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      dif.s_axis_divisor_tdata  = 32'd1;
      dif.s_axis_divisor_tvalid = 1'b1;
      sb.push_back('{dout: {32'hFFFFFFFF, 32'd0}, cyc: c0 + 3 + 33});
      @(posedge clk); #1;
      dif.s_axis_dividend_tvalid = 1'b0;
      dif.s_axis_divisor_tvalid  = 1'b0;
      wait_drain();

      for (int unsigned i = 0; i < 12; i++) begin
         send_both(vecs[i].dvd, vecs[i].dvs, vecs[i].quo, vecs[i].rem, 1'b1, hc);
         wait_drain();
      end

      for (int unsigned i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
         send_both(a, b, (b == 0) ? 32'hFFFFFFFF : a / b, (b == 0) ? a : a % b, 1'b1, hc);
         wait_drain();
      end

      // Cancel in mid-BUSY, then 50/8
      send_both(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, hc);
      repeat (9) begin @(posedge clk); #1; end
      dif.div_cancel = 1'b1;
      @(posedge clk); #1;
      dif.div_cancel = 1'b0;
      chk("cancel_treadys", 64'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 64'b11);
      send_both(32'd50, 32'd8, 32'd6, 32'd2, 1'b1, hc);
      wait_drain();

      // Cancel during the DONE cycle suppresses the pulse
      send_both(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, hc);
      repeat (32) begin @(posedge clk); #1; end
      dif.div_cancel = 1'b1;
      @(negedge clk);
      chk("cancel_done_tvalid", 64'(dif.m_axis_dout_tvalid), 64'd0);
      @(posedge clk); #1;
      dif.div_cancel = 1'b0;
      chk("cancel_done_treadys", 64'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 64'b11);

      // Back-to-back operations
      send_both(32'h80000000, 32'h10, 32'h08000000, 32'd0, 1'b1, hc);
      send_both(32'h12345678, 32'h100, 32'h00123456, 32'h78, 1'b1, h2);
      chk("b2b_gap", 64'(h2 - hc), 64'd34);
      wait_drain();

      // Reset in mid-BUSY
      send_both(32'd1000, 32'd3, 32'd0, 32'd0, 1'b0, hc);
      repeat (4) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_busy_treadys", 64'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 64'b11);

      // Reset in the DONE cycle: pulse still seen, then 7/7
      send_both(32'd9, 32'd4, 32'd2, 32'd1, 1'b1, hc);
      repeat (32) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst_done_pulse_taken", 64'(sb.size()), 64'd0);
      chk("rst_done_treadys", 64'({dif.s_axis_dividend_tready, dif.s_axis_divisor_tready}), 64'b11);
      chk("rst_done_tvalid", 64'(dif.m_axis_dout_tvalid), 64'd0);
      send_both(32'd7, 32'd7, 32'd1, 32'd0, 1'b1, hc);
      wait_drain();

      repeat (5) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion by cycle %0d, required finish", cyc);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/iter_udiv.md
# iter_udiv

Iterative radix-2 restoring unsigned divider that serves the EXE stage's divide request channel (separate dividend and divisor valid/ready channels, one 64-bit result pulse). It is the responder end of that channel. It is a drop-in replacement for the vendor divider core, with a fixed, documented latency and a cancel input for exception flushes. Signed DIV handling (operand/result negation) stays in the EXE stage. This block is purely unsigned.

## Interface
- `WIDTH`, default 32: operand width. The result is 2*WIDTH wide.
- `clk` input 1: clock, all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `s_axis_dividend_tdata` input WIDTH: dividend.
- `s_axis_dividend_tvalid` input 1: dividend offered.
- `s_axis_dividend_tready` output 1: dividend slot can accept.
- `s_axis_divisor_tdata` input WIDTH: divisor.
- `s_axis_divisor_tvalid` input 1: divisor offered.
- `s_axis_divisor_tready` output 1: divisor slot can accept.
- `m_axis_dout_tdata` output 2*WIDTH: {quotient[2W-1:W], remainder[W-1:0]}.
- `m_axis_dout_tvalid` output 1: result valid, one-cycle pulse. There is no ready; the consumer must take it.
- `div_cancel` input 1: flush. Tie to 0 for vendor-core-compatible behaviour.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - Each operand channel has its own capture register and "held" flag.
  - `*_tready` = (state==IDLE) & !held for that channel.
  - A handshake is tvalid & tready at a rising edge. It captures tdata and sets held.
  - The channels are independent. Operands may arrive in the same cycle or in different cycles, in either order.
- IDLE -> BUSY: on the edge where both operands become held (or are both already held). At that edge:
  - remainder register (WIDTH+1 bits) <= 0
  - quotient/shift register <= dividend
  - iteration counter <= 0
- BUSY: one iteration per edge.
  - r' = {r[WIDTH-1:0], q[WIDTH-1]}; q <<= 1.
  - If r' >= {1'b0, divisor}: r = r' - divisor and q[0] = 1. Otherwise r = r' and q[0] = 0.
  - After WIDTH iterations (counter == WIDTH-1 at the edge), go to DONE.
- DONE:
  - `m_axis_dout_tvalid` = 1 for exactly this one cycle.
  - tdata = {q, r[WIDTH-1:0]}.
  - Next edge: go to IDLE and clear both held flags.
- Divide by zero (divisor = 0): no special path. The algorithm naturally yields quotient = all-ones and remainder = dividend. This result is required, not just tolerated.
- Cancel (`div_cancel` = 1 at an edge):
  - state <= IDLE, both held flags cleared, any handshake in that same cycle is ignored.
  - `m_axis_dout_tvalid` is forced to 0 combinationally while `div_cancel` is high, including in DONE.
- Priority: reset > div_cancel > normal operation.
- Outside DONE, `m_axis_dout_tdata` holds the last computed value. Its value is undefined as long as tvalid=0; the bench must not check it then.

## Timing
- Reset values:
  - state = IDLE, held flags = 0, counter = 0, remainder/quotient registers = 0.
  - `s_axis_dividend_tready` = 1, `s_axis_divisor_tready` = 1, `m_axis_dout_tvalid` = 0, `m_axis_dout_tdata` = 0.
- Latency: let edge E0 be the edge that completes the second operand handshake.
  - BUSY covers E1..E(WIDTH).
  - tvalid is high in the cycle after edge E(WIDTH). For WIDTH=32 that is 33 cycles after E0.
  - Fixed latency; it does not depend on the data.
- Both treadys are low from E0 until the edge after the DONE cycle.
- The earliest next handshake is the cycle after the tvalid pulse.
- The throughput limit is one division per WIDTH+2 cycles.
- A held operand ignores further tvalid on its channel (tready = 0) until the operation completes or is cancelled.
- Reset or cancel in mid-BUSY: the operation is abandoned and no result pulse is produced. Treadys are high in the next cycle.

## Test plan
- 100 / 7, both operands in the same cycle (E0):
  - tvalid exactly at E0+33, dout = {32'd14, 32'd2}.
  - tready low during E0+1..E0+33.
- Dividend 0xFFFFFFFF at cycle 0, divisor 0x00000001 at cycle 3:
  - Dividend tready drops after cycle 0.
  - Result at cycle 3+33, {0xFFFFFFFF, 0}.
- 5 / 0 -> {0xFFFFFFFF, 32'd5}. Also 0 / 9 -> {0, 0}.
- Start 1000/3, assert `div_cancel` at iteration 10:
  - No tvalid is ever produced for it.
  - Next cycle both treadys = 1.
  - A new 50/8 yields {6, 2} 33 cycles after its handshake.
- Back-to-back: 0x80000000/0x10 then 0x12345678/0x100, with the second issued in the cycle after the first tvalid.
  - Results {0x08000000, 0} and {0x00123456, 0x78}.
  - Exactly 34 cycles apart.
- Reset asserted in the DONE cycle:
  - tvalid still pulses that cycle (the reset is synchronous).
  - Afterwards all registers hold their reset values, and a subsequent 7/7 yields {1, 0}.
